// File: rtl/adder_tree_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adder_tree_pkg
// Description : Shared constants and state encoding for the packet
//               accumulator (adder_tree_acc_8bit).
//               MAX_OPS - maximum operands per packet
//               ACC_W   - accumulator / sum width
//               CNT_W   - operand counter width
//               state_t - IDLE / ACC / HOLD
// Revision    : 1.0 - initial release
// ============================================================================
package adder_tree_pkg;

    localparam int MAX_OPS = 16;
    localparam int ACC_W   = 12;
    localparam int CNT_W   = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage : adder_tree_pkg
`default_nettype wire

// File: rtl/cla_8bit.sv
`default_nettype none
// ============================================================================
// Module      : cla_8bit
// Description : 8-bit carry-lookahead adder built from two 4-bit lookahead
//               groups; the second group's carry-in is the first group's
//               lookahead carry-out.
// Ports       : i_a, i_b  - 8-bit operands
//               i_cin     - carry in
//               o_sum     - 8-bit sum
//               o_cout    - carry out
// Revision    : 1.0 - initial release
// ============================================================================
module cla_8bit (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic       i_cin,
    output logic [7:0] o_sum,
    output logic       o_cout
);

    logic [7:0] w_p;
    logic [7:0] w_g;
    logic [8:0] w_c;

    assign w_p    = i_a ^ i_b;
    assign w_g    = i_a & i_b;
    assign w_c[0] = i_cin;

    // Each group expands its carries directly from the group carry-in.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_grp
            localparam int c_base = gi * 4;
            assign w_c[c_base+1] = w_g[c_base]
                                 | (w_p[c_base] & w_c[c_base]);
            assign w_c[c_base+2] = w_g[c_base+1]
                                 | (w_p[c_base+1] & w_g[c_base])
                                 | (w_p[c_base+1] & w_p[c_base] & w_c[c_base]);
            assign w_c[c_base+3] = w_g[c_base+2]
                                 | (w_p[c_base+2] & w_g[c_base+1])
                                 | (w_p[c_base+2] & w_p[c_base+1] & w_g[c_base])
                                 | (w_p[c_base+2] & w_p[c_base+1] & w_p[c_base] & w_c[c_base]);
            assign w_c[c_base+4] = w_g[c_base+3]
                                 | (w_p[c_base+3] & w_g[c_base+2])
                                 | (w_p[c_base+3] & w_p[c_base+2] & w_g[c_base+1])
                                 | (w_p[c_base+3] & w_p[c_base+2] & w_p[c_base+1] & w_g[c_base])
                                 | (w_p[c_base+3] & w_p[c_base+2] & w_p[c_base+1] & w_p[c_base] & w_c[c_base]);
        end
    endgenerate

    assign o_sum  = w_p ^ w_c[7:0];
    assign o_cout = w_c[8];

endmodule : cla_8bit
`default_nettype wire

// File: rtl/adder_tree_acc_8bit.sv
`default_nettype none
// ============================================================================
// Module      : adder_tree_acc_8bit
// Description : Packet accumulator. Sums a packet of unsigned 8-bit operands
//               (closed by in_last or by reaching MAX_OPS operands) and
//               presents the sum/count until the consumer takes it.
// Ports       : clk, rst              - clock, synchronous active-high reset
//               in_valid/in_ready     - operand handshake
//               in_data, in_last      - operand and end-of-packet marker
//               out_valid/out_ready   - result handshake
//               out_sum, out_count    - packet sum and operand count
//               out_trunc             - packet closed by operand limit
// Revision    : 1.0 - initial release
// ============================================================================
module adder_tree_acc_8bit
    import adder_tree_pkg::*;
#(
    parameter int MAX_OPS = adder_tree_pkg::MAX_OPS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_trunc
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] w_acc_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic             r_trunc;
    logic             w_trunc_nxt;

    logic [7:0]       w_lo_sum;
    logic             w_lo_cout;
    logic             w_accept;
    logic [CNT_W-1:0] w_count_inc;
    logic             w_limit;

    cla_8bit u_cla (
        .i_a    (r_acc[7:0]),
        .i_b    (in_data),
        .i_cin  (1'b0),
        .o_sum  (w_lo_sum),
        .o_cout (w_lo_cout)
    );

    assign in_ready    = (r_state != HOLD);
    assign w_accept    = in_valid & in_ready;
    assign w_count_inc = r_count + CNT_W'(1);
    assign w_limit     = (w_count_inc == CNT_W'(MAX_OPS));

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_count_nxt = r_count;
        w_trunc_nxt = r_trunc;
        case (r_state)
            IDLE, ACC: begin
                if (w_accept) begin
                    // Low byte through the CLA; its carry bumps the upper bits.
                    w_acc_nxt   = {r_acc[ACC_W-1:8] + (ACC_W-8)'(w_lo_cout), w_lo_sum};
                    w_count_nxt = w_count_inc;
                    if (in_last || w_limit) begin
                        w_state_nxt = HOLD;
                        // in_last wins: a marked final operand is never a truncation.
                        w_trunc_nxt = w_limit & ~in_last;
                    end else begin
                        w_state_nxt = ACC;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                    w_acc_nxt   = '0;
                    w_count_nxt = '0;
                    w_trunc_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_acc_nxt   = '0;
                w_count_nxt = '0;
                w_trunc_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_acc   <= '0;
            r_count <= '0;
            r_trunc <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_acc   <= w_acc_nxt;
            r_count <= w_count_nxt;
            r_trunc <= w_trunc_nxt;
        end
    end

    // Result fields are forced to zero whenever no result is presented.
    assign out_valid = (r_state == HOLD);
    assign out_sum   = out_valid ? r_acc   : '0;
    assign out_count = out_valid ? r_count : '0;
    assign out_trunc = out_valid & r_trunc;

endmodule : adder_tree_acc_8bit
`default_nettype wire

// File: tb/tb_adder_tree_acc_8bit.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_tree_acc_8bit
// Description : Self-checking bench for adder_tree_acc_8bit: a table of
//               single-packet vectors plus hand-written multi-cycle sequences
//               (output backpressure, reset mid-packet, input bubbles,
//               operand-limit stall, reset overriding handshakes).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_tree_acc_8bit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_sum;
    logic [4:0]  out_count;
    logic        out_trunc;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    adder_tree_acc_8bit #(.MAX_OPS(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count),
        .out_trunc (out_trunc)
    );

    typedef struct {
        logic [127:0] ops;
        int           n;
        logic         last;
        logic [11:0]  e_sum;
        logic [4:0]   e_cnt;
        logic         e_trunc;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!in_ready && k < 20) begin
            tick();
            k++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic send_pkt(input logic [127:0] ops, input int n, input logic last);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = ops[i*8 +: 8];
            in_last  = last && (i == n - 1);
            wait_ready();
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic check_out(input string tag, input logic [11:0] s, input logic [4:0] c, input logic t);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_sum"},   32'(out_sum),   32'(s));
        chk({tag, "_count"}, 32'(out_count), 32'(c));
        chk({tag, "_trunc"}, 32'(out_trunc), 32'(t));
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_post_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_post_sum"},   32'(out_sum),   32'd0);
        chk({tag, "_post_ready"}, 32'(in_ready),  32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] ops;

        // ---------------- vector table ----------------
        vecs[0] = '{ops: 128'h7F, n: 1, last: 1'b1, e_sum: 12'h07F, e_cnt: 5'd1, e_trunc: 1'b0};
        vecs[1] = '{ops: 128'h01FF, n: 2, last: 1'b1, e_sum: 12'h100, e_cnt: 5'd2, e_trunc: 1'b0};
        vecs[2] = '{ops: {16{8'hFF}}, n: 16, last: 1'b0, e_sum: 12'hFF0, e_cnt: 5'd16, e_trunc: 1'b1};
        ops = '0;
        for (int j = 0; j < 16; j++) ops[j*8 +: 8] = 8'(j + 1);
        vecs[3] = '{ops: ops, n: 16, last: 1'b1, e_sum: 12'h088, e_cnt: 5'd16, e_trunc: 1'b0};
        vecs[4] = '{ops: 128'h808080, n: 3, last: 1'b1, e_sum: 12'h180, e_cnt: 5'd3, e_trunc: 1'b0};

        // ---------------- reset state ----------------
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_sum",   32'(out_sum),   32'd0);
        chk("rst_count", 32'(out_count), 32'd0);
        chk("rst_trunc", 32'(out_trunc), 32'd0);
        rst = 1'b0;
        tick();
        chk("rst_ready", 32'(in_ready), 32'd1);

        // ---------------- table-driven packets ----------------
        for (int v = 0; v < 5; v++) begin
            send_pkt(vecs[v].ops, vecs[v].n, vecs[v].last);
            check_out($sformatf("vec%0d", v), vecs[v].e_sum, vecs[v].e_cnt, vecs[v].e_trunc);
            chk($sformatf("vec%0d_hold_ready", v), 32'(in_ready), 32'd0);
            handshake($sformatf("vec%0d", v));
        end

        // ---------------- 17th operand stalled at the limit ----------------
        send_pkt({16{8'hFF}}, 16, 1'b0);
        in_valid = 1'b1; in_data = 8'h55; in_last = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("stall_ready", 32'(in_ready), 32'd0);
            tick();
        end
        check_out("stall", 12'hFF0, 5'd16, 1'b1);
        in_valid = 1'b0; in_last = 1'b0;
        handshake("stall");

        // ---------------- output backpressure ----------------
        send_pkt(128'h2010, 2, 1'b1);
        for (int k = 0; k < 3; k++) begin
            check_out("bp", 12'h030, 5'd2, 1'b0);
            chk("bp_ready", 32'(in_ready), 32'd0);
            tick();
        end
        check_out("bp_last", 12'h030, 5'd2, 1'b0);
        handshake("bp");

        // ---------------- reset mid-packet ----------------
        send_pkt(128'h070605, 3, 1'b0);
        chk("mid_valid", 32'(out_valid), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        send_pkt(128'h01, 1, 1'b1);
        check_out("mid", 12'h001, 5'd1, 1'b0);
        handshake("mid");

        // ---------------- reset overrides accept ----------------
        in_valid = 1'b1; in_data = 8'h44; in_last = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0; in_valid = 1'b0;
        send_pkt(128'h01, 1, 1'b1);
        check_out("rst_acc", 12'h001, 5'd1, 1'b0);

        // ---------------- reset overrides output handshake in HOLD ----------------
        out_ready = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; out_ready = 1'b0;
        chk("rst_hold_valid", 32'(out_valid), 32'd0);
        chk("rst_hold_ready", 32'(in_ready),  32'd1);

        // ---------------- input bubbles ----------------
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_data = 8'(i); in_last = (i == 4);
            tick();
            if (i < 4) begin
                in_valid = 1'b0; in_data = 8'hAA; in_last = 1'b1;
                tick();
                chk("bub_valid", 32'(out_valid), 32'd0);
            end
        end
        in_valid = 1'b0; in_last = 1'b0; in_data = 8'h00;
        check_out("bub", 12'h00A, 5'd4, 1'b0);
        handshake("bub");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_adder_tree_acc_8bit
`default_nettype wire
